// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction buffer between the fetch stage and the IF/ID pipeline register.
// Fetch can run ahead of decode by up to DEPTH instructions. A flush (branch,
// return or page fault) discards every buffered entry. While the buffer is
// empty, decode sees a NOP bubble.
//
// Optional feature (macro IFQ_BYPASS_EN):
//   defined   - When the queue is empty, a valid fetch is forwarded
//               combinationally to the head outputs. If decode takes it in
//               that cycle, it is never written into the array.
//   undefined - One-cycle latency from push to head. There is no
//               combinational path from if_* to id_*.
//
// Ports:
//   clk       in   core clock
//   rstn      in   asynchronous active-low reset
//   flush     in   discard all entries; any push/pop this cycle is ignored
//   if_valid  in   fetch presents an instruction this cycle
//   if_pc     in   PC of the fetched instruction
//   if_inst   in   fetched instruction word
//   if_ready  out  queue can accept a push (not full); depends on state only
//   id_stall  in   decode stalled, no pop this cycle
//   id_valid  out  id_pc/id_inst hold a real instruction
//   id_pc     out  PC at the head of the queue (0 when empty)
//   id_inst   out  instruction at the head, or NOP_INST when empty
//   level     out  current occupancy, 0..DEPTH
//   afull     out  registered flag, level >= AFULL_LVL
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int              DEPTH     = 4,
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              AFULL_LVL = DEPTH - 1,
  parameter logic [ILEN-1:0] NOP_INST  = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [XLEN-1:0]          if_pc,
  input  logic [ILEN-1:0]          if_inst,
  output logic                     if_ready,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [ILEN-1:0]          id_inst,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LVL);

  // Storage array. There is no reset on the array: only the pointers decide
  // which entries are meaningful.
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];

  // The pointers carry one extra wrap bit. Equal pointers mean empty. Equal
  // index bits with different wrap bits mean full.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] level_nxt;
  logic          afull_q;

  logic empty, full;
  logic push, pop;
  logic bypass_hit;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Subtraction modulo 2^PW gives the occupancy across any number of wraps.
  assign level    = wr_ptr - rd_ptr;
  assign if_ready = ~full;
  assign afull    = afull_q;

`ifdef IFQ_BYPASS_EN
  // An empty queue forwards the incoming fetch straight to decode.
  assign bypass_hit = empty & if_valid & ~flush;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed instruction that decode consumes right away is not stored.
  // Pop only ever drains real entries. A bypassed word is not in the array,
  // so it must not advance rd_ptr.
  assign push = if_valid & if_ready & ~flush & ~(bypass_hit & ~id_stall);
  assign pop  = ~empty & ~id_stall & ~flush;

  // Next pointer values. Flush has the highest priority: it rewinds both
  // pointers to zero and ignores any push or pop in the same cycle.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

  // Pointer and almost-full state. afull is computed from the next-state
  // occupancy, so it changes in the cycle after the crossing push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      afull_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      afull_q <= (level_nxt >= AFULL_THR);
    end
  end

  // Array write on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= if_pc;
      inst_mem[wr_ptr[AW-1:0]] <= if_inst;
    end
  end

  // Head outputs. These are combinational reads of the entry at rd_ptr.
  // When empty, decode sees a NOP bubble, or the bypassed fetch if bypass
  // is enabled.
  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = NOP_INST;
    if (!empty) begin
      id_valid = 1'b1;
      id_pc    = pc_mem[rd_ptr[AW-1:0]];
      id_inst  = inst_mem[rd_ptr[AW-1:0]];
    end else if (bypass_hit) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_inst  = if_inst;
    end
  end

endmodule
